matrix_wb_bridge: RTL
=====================

Name: matrix_wb_bridge

Overview:
- Wishbone-slave to Matrix_TOP adapter, sitting directly upstream of Matrix_TOP; the SERV data bus is the master.
- Converts single-word bus transactions into the accelerator's data/address/we pulse protocol, with setup and hold timing.
- Auto-generates the start-bit deassert write.
- Polls the done status after a start and raises a sticky interrupt.

Parameters:
- WE_HOLD_CYCLES, 3, cycles o_mat_we stays high per forwarded write (>=1).
- RD_LATENCY, 2, cycles the address is held before i_mat_rdt is sampled (>=1).

Ports:
- CLOCK_25  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- i_wb_adr  in  32  byte address; word address = i_wb_adr[14:2].
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables.
- i_wb_we  in  1  1=write, 0=read.
- i_wb_cyc  in  1  transaction request.
- o_wb_rdt  out  32  read data, valid while o_wb_ack=1.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_mat_data  out  32  data to Matrix_TOP.
- o_mat_address  out  13  word address to Matrix_TOP: [12:10] region, [9:5] row, [4:0] column.
- o_mat_we  out  1  write strobe to Matrix_TOP.
- i_mat_rdt  in  32  Matrix_TOP read data.
- o_irq  out  1  sticky done interrupt.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; run_pending=0. Reset asserted mid-transaction aborts it with no ack.
- Region map (wa = word address):
  - wa[12:10]=0: control; bit31=start, [23:16]=B cols, [15:8]=A cols, [7:0]=A rows.
  - 1: matrix A. 2: matrix B. 3: matrix C (read). 4: status, bit0=done. 5-7: unmapped.
- FSM states: IDLE, WSETUP, WHOLD, WCLEAR, RWAIT, ACK.
- Accept: in IDLE with i_wb_cyc=1 and o_wb_ack=0.
  - On accept edge k, latch wa and i_wb_dat, drive o_mat_address=wa and o_mat_data=dat.
  - i_wb_cyc is ignored in all other states.
- Forwarded write (region 0-3 with i_wb_sel=4'hF; regions 1-3 forwarded as-is):
  - WSETUP for 1 cycle (k+1, we=0), then WHOLD with o_mat_we=1 for cycles k+2..k+1+WE_HOLD_CYCLES.
  - Region 0 with dat[31]=1 -> WCLEAR: o_mat_data[31] cleared, others kept, then a second WSETUP+WHOLD; at the end set run_pending=1.
  - Then ACK.
  - Ack cycle: plain write k+2+H; start write k+3+2H (H=WE_HOLD_CYCLES).
- Unforwarded writes (no o_mat_we pulse, go straight to ACK, acked at k+1):
  - Region 4 write: if dat[0]=1, clear o_irq.
  - Region 5-7 write.
  - Any write with i_wb_sel != 4'hF.
- Read, region 0-4: RWAIT holds o_mat_address for RD_LATENCY cycles, samples i_mat_rdt into o_wb_rdt on the final edge, ack at k+1+RD_LATENCY.
- Read, region 5-7: o_wb_rdt=0, ack at k+1.
- ACK: o_wb_ack=1 for exactly 1 cycle, then IDLE.
  - If i_wb_cyc=0 in the ACK cycle, the ack is suppressed; the matrix-side effect stands.
  - o_wb_rdt is held until the next read completes.
- Done polling (IDLE with run_pending=1 and no request):
  - Drive o_mat_address={3'd4,10'd0}, o_mat_we=0.
  - Once the address has been stable RD_LATENCY cycles, sample each cycle; on i_mat_rdt[0]=1, set o_irq=1 and clear run_pending.
  - A bus request arriving in the same cycle wins; polling restarts its latency count afterwards.
  - o_irq set and W1C clear in the same cycle: the set wins.
- o_mat_we is never high outside WHOLD; o_mat_address/o_mat_data are stable for the whole WSETUP+WHOLD window.

Test Plan:
- Reset: RESET_N low mid-WHOLD -> o_mat_we and o_wb_ack drop asynchronously, all outputs 0; next write after release completes normally.
- Write adr 0x0000_1004 (wa=0x401, A[0][1]), dat=2, sel=F at edge k -> o_mat_address=0x0401, o_mat_we high k+2..k+4, ack at k+5.
- Start write adr 0x0, dat=0x8003_0303:
  - Two 3-cycle we pulses, data 0x8003_0303 then 0x0003_0303; ack at k+9.
  - Model raises i_mat_rdt=1 on status 20 cycles later -> o_irq=1 at most RD_LATENCY+1 cycles after.
- Read result C[1][2] adr 0x0000_3088 (wa=0xC22), model returns 0x0000_0042 -> o_wb_rdt=0x42 with ack at k+3; o_mat_we stays 0.
- Edge cases:
  - Write sel=4'h3 -> ack at k+1, no we pulse.
  - Read region 6 -> rdt=0, ack k+1.
  - Write 1 to status while o_irq=1 -> o_irq=0.
- Bus request arriving during done polling -> request served first, polling resumes, o_irq still set once done=1.

Source files
------------

// File: rtl/matrix_wb_bridge.sv
// Wishbone slave front-end for Matrix_TOP: turns single-word bus cycles into the
// accelerator's address/data/we pulse protocol and polls for completion after a start.
module matrix_wb_bridge #(
   parameter int unsigned WE_HOLD_CYCLES = 3,
   parameter int unsigned RD_LATENCY     = 2
) (
   input  logic        CLOCK_25,
   input  logic        RESET_N,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic [31:0] o_mat_data,
   output logic [12:0] o_mat_address,
   output logic        o_mat_we,
   input  logic [31:0] i_mat_rdt,
   output logic        o_irq
);

   localparam int unsigned MAX_CNT = (WE_HOLD_CYCLES > RD_LATENCY) ? WE_HOLD_CYCLES : RD_LATENCY;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WE_HOLD_CYCLES);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LATENCY);
   localparam logic [2:0]  RGN_CTRL    = 3'd0;
   localparam logic [2:0]  RGN_C       = 3'd3;
   localparam logic [2:0]  RGN_STATUS  = 3'd4;
   localparam logic [12:0] STATUS_ADDR = {3'd4, 10'd0};

   typedef enum logic [2:0] {IDLE, WSETUP, WHOLD, WCLEAR, RWAIT, ACK} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             start_wr;
   logic             run_pending;
   logic             poll_active;

   logic [12:0] wa_c;
   logic [2:0]  rgn_c;
   logic        req_c;
   logic        fwd_wr_c;
   logic        irq_clr_c;
   logic        poll_hit_c;
   logic        adr_unused_c;

   assign wa_c         = i_wb_adr[14:2];
   assign rgn_c        = wa_c[12:10];
   assign req_c        = i_wb_cyc & ~o_wb_ack;
   assign fwd_wr_c     = i_wb_we && (rgn_c <= RGN_C) && (i_wb_sel == 4'hF);
   assign irq_clr_c    = (state == IDLE) && req_c && i_wb_we && (rgn_c == RGN_STATUS) && i_wb_dat[0];
   assign poll_hit_c   = (state == IDLE) && !req_c && run_pending && poll_active &&
                         (cnt >= RD_LAST) && i_mat_rdt[0];
   assign adr_unused_c = ^{i_wb_adr[31:15], i_wb_adr[1:0]};

   // Bus FSM, matrix strobe timing and done polling share one counter.
   always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         cnt           <= '0;
         start_wr      <= 1'b0;
         run_pending   <= 1'b0;
         poll_active   <= 1'b0;
         o_wb_rdt      <= '0;
         o_wb_ack      <= 1'b0;
         o_mat_data    <= '0;
         o_mat_address <= '0;
         o_mat_we      <= 1'b0;
         o_irq         <= 1'b0;
      end else begin
         // A done hit beats a simultaneous write-one-to-clear.
         o_irq <= poll_hit_c | (o_irq & ~irq_clr_c);
         case (state)
            IDLE: begin
               if (req_c) begin
                  o_mat_address <= wa_c;
                  o_mat_data    <= i_wb_dat;
                  poll_active   <= 1'b0;
                  start_wr      <= fwd_wr_c && (rgn_c == RGN_CTRL) && i_wb_dat[31];
                  cnt           <= CNT_W'(1);
                  if (fwd_wr_c) begin
                     state <= WSETUP;
                  end else if (!i_wb_we && (rgn_c <= RGN_STATUS)) begin
                     state <= RWAIT;
                  end else begin
                     if (!i_wb_we) o_wb_rdt <= '0;
                     o_wb_ack <= 1'b1;
                     state    <= ACK;
                  end
               end else if (run_pending) begin
                  if (!poll_active) begin
                     o_mat_address <= STATUS_ADDR;
                     poll_active   <= 1'b1;
                     cnt           <= CNT_W'(1);
                  end else if (cnt >= RD_LAST) begin
                     if (i_mat_rdt[0]) begin
                        run_pending <= 1'b0;
                        poll_active <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            // WCLEAR doubles as the setup cycle of the start-clear write.
            WSETUP, WCLEAR: begin
               o_mat_we <= 1'b1;
               cnt      <= CNT_W'(1);
               state    <= WHOLD;
            end
            WHOLD: begin
               if (cnt == HOLD_LAST) begin
                  o_mat_we <= 1'b0;
                  if (start_wr && o_mat_data[31]) begin
                     o_mat_data[31] <= 1'b0;
                     state          <= WCLEAR;
                  end else begin
                     if (start_wr) run_pending <= 1'b1;
                     o_wb_ack <= i_wb_cyc;
                     state    <= ACK;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RWAIT: begin
               if (cnt == RD_LAST) begin
                  o_wb_rdt <= i_mat_rdt;
                  o_wb_ack <= i_wb_cyc;
                  state    <= ACK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ACK: begin
               o_wb_ack <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
